// File: rtl/player_hit_ctrl.sv
// player_hit_ctrl
//   Character-vs-boss contact damage controller. Registers a box-overlap flag
//   every clock, applies CONTACT_DMG once per hit on frame ticks, then holds the
//   player invulnerable for IFRAME_FRAMES frame ticks. Reaching 0 HP latches the
//   player dead until game_active drops, which reloads the player for a new game.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   frame_tick        one-cycle pulse per video frame
//   game_active       high while gameplay runs; low reloads the player
//   char_x, char_y    character box top-left corner (box is CHAR_LNG x CHAR_HGT)
//   boss_x, boss_y    boss box top-left corner
//   boss_lng, boss_hgt boss box width / height
//   boss_hp           boss HP, 0 = defeated (harmless)
//   player_hp         current player HP
//   hit_pulse         one-cycle pulse per applied hit
//   invuln            high during the invulnerability window
//   player_dead       high while player HP is 0
module player_hit_ctrl #(
    parameter int unsigned CHAR_LNG      = 48,
    parameter int unsigned CHAR_HGT      = 64,
    parameter int unsigned PLAYER_HP_MAX = 6,
    parameter int unsigned CONTACT_DMG   = 1,
    parameter int unsigned IFRAME_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        game_active,
    input  logic [11:0] char_x,
    input  logic [11:0] char_y,
    input  logic [11:0] boss_x,
    input  logic [11:0] boss_y,
    input  logic [11:0] boss_lng,
    input  logic [11:0] boss_hgt,
    input  logic [6:0]  boss_hp,
    output logic [3:0]  player_hp,
    output logic        hit_pulse,
    output logic        invuln,
    output logic        player_dead
);

    localparam int unsigned CNT_W = (IFRAME_FRAMES < 2) ? 1 : $clog2(IFRAME_FRAMES + 1);

    localparam logic [1:0] ST_ALIVE  = 2'd0;
    localparam logic [1:0] ST_INVULN = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    localparam logic [3:0]       HP_MAX      = 4'(PLAYER_HP_MAX);
    localparam logic [3:0]       DMG         = (CONTACT_DMG > 15) ? 4'hF : 4'(CONTACT_DMG);
    localparam logic [CNT_W-1:0] IFRAME_LOAD = CNT_W'(IFRAME_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       hp_q, hp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic             overlap_q, overlap_d;

    // Right/bottom edges at 13 bits so 12-bit coordinates plus sizes never wrap.
    logic [12:0] boss_r, boss_b, char_r, char_b;

    always_comb begin
        boss_r    = {1'b0, boss_x} + {1'b0, boss_lng};
        boss_b    = {1'b0, boss_y} + {1'b0, boss_hgt};
        char_r    = {1'b0, char_x} + 13'(CHAR_LNG);
        char_b    = {1'b0, char_y} + 13'(CHAR_HGT);
        // Strict compares: boxes sharing only an edge do not overlap.
        overlap_d = ({1'b0, char_x} < boss_r) && ({1'b0, boss_x} < char_r) &&
                    ({1'b0, char_y} < boss_b) && ({1'b0, boss_y} < char_b);
    end

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        if (!game_active) begin
            // Game restart outranks any coincident frame tick.
            state_d = ST_ALIVE;
            hp_d    = HP_MAX;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ALIVE: begin
                    if (frame_tick && overlap_q && (boss_hp != '0)) begin
                        hit_d = 1'b1;
                        hp_d  = (hp_q > DMG) ? (hp_q - DMG) : '0;
                        if (hp_d == '0) begin
                            state_d = ST_DEAD;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_INVULN;
                            cnt_d   = IFRAME_LOAD;
                        end
                    end
                end
                ST_INVULN: begin
                    if (frame_tick) begin
                        if (cnt_q <= CNT_ONE) begin
                            cnt_d   = '0;
                            state_d = ST_ALIVE;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                ST_DEAD: begin
                    hp_d  = '0;
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_ALIVE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ALIVE;
            hp_q      <= HP_MAX;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            overlap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hp_q      <= hp_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            overlap_q <= overlap_d;
        end
    end

    assign player_hp   = hp_q;
    assign hit_pulse   = hit_q;
    assign invuln      = (state_q == ST_INVULN);
    assign player_dead = (state_q == ST_DEAD);

endmodule

// File: tb/tb_player_hit_ctrl.sv
module tb_player_hit_ctrl;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        game_active;
    logic [11:0] char_x, char_y;
    logic [11:0] boss_x, boss_y, boss_lng, boss_hgt;
    logic [6:0]  boss_hp;

    logic [3:0]  hp_a, hp_b;
    logic        hit_a, hit_b, inv_a, inv_b, dead_a, dead_b;

    int checks;
    int errors;
    int hits_a;
    int hits_b;
    int consec_a;

    player_hit_ctrl u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .char_x(char_x), .char_y(char_y), .boss_x(boss_x), .boss_y(boss_y),
        .boss_lng(boss_lng), .boss_hgt(boss_hgt), .boss_hp(boss_hp),
        .player_hp(hp_a), .hit_pulse(hit_a), .invuln(inv_a), .player_dead(dead_a)
    );

    player_hit_ctrl #(.IFRAME_FRAMES(1)) u_dut_fast (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .char_x(char_x), .char_y(char_y), .boss_x(boss_x), .boss_y(boss_y),
        .boss_lng(boss_lng), .boss_hgt(boss_hgt), .boss_hp(boss_hp),
        .player_hp(hp_b), .hit_pulse(hit_b), .invuln(inv_b), .player_dead(dead_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame tick; afterwards hit_pulse for that tick is visible.
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        if (hit_a) hits_a++;
        if (hit_b) hits_b++;
        @(negedge clk);
        if (hit_a && hit_b === 1'b1 && 1'b0) hits_b++;
        if (hit_a) consec_a++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_char(input int x, input int y);
        @(negedge clk);
        char_x = 12'(x);
        char_y = 12'(y);
        idle(2);
    endtask

    task automatic restart();
        @(negedge clk);
        game_active = 1'b0;
        @(negedge clk);
        game_active = 1'b1;
        idle(1);
    endtask

    initial begin
        checks = 0; errors = 0; hits_a = 0; hits_b = 0; consec_a = 0;
        rst = 1'b1; frame_tick = 1'b0; game_active = 1'b1;
        char_x = '0; char_y = '0;
        boss_x = 12'd400; boss_y = 12'd300; boss_lng = 12'd106; boss_hgt = 12'd95;
        boss_hp = 7'd50;
        idle(3);
        check_eq("rst_hp", hp_a, 6);
        check_eq("rst_hit", hit_a, 0);
        check_eq("rst_invuln", inv_a, 0);
        check_eq("rst_dead", dead_a, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Boxes apart
        ticks(10);
        check_eq("apart_hp", hp_a, 6);
        check_eq("apart_hits", hits_a, 0);
        check_eq("apart_invuln", inv_a, 0);

        // First contact
        set_char(380, 290);
        hits_a = 0; consec_a = 0;
        tick();
        check_eq("hit1_pulse", hits_a, 1);
        check_eq("hit1_hp", hp_a, 5);
        check_eq("hit1_invuln", inv_a, 1);
        check_eq("hit1_no_consec", consec_a, 0);

        // Invulnerability: 60 ticks without damage, then tick 61 hits
        hits_a = 0;
        ticks(60);
        check_eq("iframe_hits", hits_a, 0);
        check_eq("iframe_hp", hp_a, 5);
        check_eq("iframe_end_invuln", inv_a, 0);
        tick();
        check_eq("rehit_pulse", hits_a, 1);
        check_eq("rehit_hp", hp_a, 4);
        check_eq("rehit_invuln", inv_a, 1);

        // game_active fall coinciding with a tick: reload wins
        @(negedge clk);
        frame_tick = 1'b1;
        game_active = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0;
        check_eq("fall_tick_hp", hp_a, 6);
        check_eq("fall_tick_hit", hit_a, 0);
        check_eq("fall_tick_invuln", inv_a, 0);
        game_active = 1'b1;
        idle(1);

        // Edge touch on x, then one pixel of overlap
        set_char(352, 290);
        hits_a = 0;
        tick();
        check_eq("edge_x_hits", hits_a, 0);
        check_eq("edge_x_hp", hp_a, 6);
        set_char(380, 236);
        tick();
        check_eq("edge_y_hits", hits_a, 0);
        set_char(353, 290);
        tick();
        check_eq("edge_in_hits", hits_a, 1);
        check_eq("edge_in_hp", hp_a, 5);

        // Defeated boss is harmless
        restart();
        @(negedge clk);
        boss_hp = 7'd0;
        set_char(380, 290);
        hits_a = 0;
        ticks(3);
        check_eq("boss_dead_hits", hits_a, 0);
        check_eq("boss_dead_hp", hp_a, 6);

        // Death with a 1-frame window: hits on ticks 1,3,5,7,9,11
        @(negedge clk);
        boss_hp = 7'd50;
        restart();
        hits_b = 0;
        ticks(14);
        check_eq("death_hits", hits_b, 6);
        check_eq("death_hp", hp_b, 0);
        check_eq("death_flag", dead_b, 1);
        check_eq("death_invuln", inv_b, 0);
        restart();
        check_eq("restart_hp", hp_b, 6);
        check_eq("restart_dead", dead_b, 0);

        // Async reset in the middle of an invulnerability window
        hits_a = 0;
        tick();
        check_eq("pre_rst_hit", hits_a, 1);
        ticks(30);
        check_eq("pre_rst_hp", hp_a, 5);
        check_eq("pre_rst_invuln", inv_a, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("async_rst_hp", hp_a, 6);
        check_eq("async_rst_invuln", inv_a, 0);
        check_eq("async_rst_hit", hit_a, 0);
        check_eq("async_rst_dead", dead_a, 0);
        idle(2);
        rst = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Independent watchdog so the bench always terminates.
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_hit_ctrl.md
Name: player_hit_ctrl

Overview:
- Downstream consumer of the boss block. Takes the boss bounding box (boss_x, boss_y, boss_hgt, boss_lng) and boss_hp, plus the character position.
- Detects contact between character and boss, applies contact damage to the player once per hit, and enforces an invulnerability window in frames.
- Outputs player HP, a hit pulse and a death flag, consumed by the HUD renderer and the game-state controller.

Parameters:
- CHAR_LNG, 48, character box width in pixels
- CHAR_HGT, 64, character box height in pixels
- PLAYER_HP_MAX, 6, HP loaded at reset and at game restart (must be 1..15)
- CONTACT_DMG, 1, HP removed per contact hit
- IFRAME_FRAMES, 60, invulnerability length in frame_ticks (must be >= 1)

Ports:
- clk  in  1  system clock (65 MHz pixel clock domain)
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame (60 Hz)
- game_active  in  1  high while gameplay runs
- char_x  in  12  character box left edge, pixels
- char_y  in  12  character box top edge, pixels
- boss_x  in  12  boss box left edge
- boss_y  in  12  boss box top edge
- boss_lng  in  12  boss box width
- boss_hgt  in  12  boss box height
- boss_hp  in  7  boss HP; 0 means the boss is defeated
- player_hp  out  4  current player HP
- hit_pulse  out  1  one-cycle pulse on each applied hit
- invuln  out  1  high during the invulnerability window
- player_dead  out  1  high while the player HP is 0

Behaviour:
- Reset (async, rst=1):
  - player_hp=PLAYER_HP_MAX, state=ALIVE, iframe counter=0.
  - hit_pulse=0, invuln=0, player_dead=0, overlap_q=0.
- Overlap stage (registered every clk, 1-cycle latency):
  - overlap_q = (char_x < boss_x+boss_lng) && (boss_x < char_x+CHAR_LNG) && (char_y < boss_y+boss_hgt) && (boss_y < char_y+CHAR_HGT).
  - All sums computed at 13 bits, so there is no wrap.
  - Comparisons are strict: edge-touching boxes do not overlap.
- Damage is evaluated only in cycles with frame_tick=1, using overlap_q. State and outputs update on the following clk edge.
- FSM states: ALIVE, INVULN, DEAD.
  - ALIVE: on frame_tick && game_active && overlap_q && boss_hp!=0:
    - player_hp <= sat(player_hp - CONTACT_DMG), floored at 0.
    - hit_pulse <= 1 for exactly one cycle.
    - If the new HP is 0, go to DEAD. Otherwise go to INVULN with counter=IFRAME_FRAMES.
  - INVULN: invuln=1. On each frame_tick the counter decrements. On the tick where counter==1, counter goes to 0 and the state goes to ALIVE.
    - Overlap is ignored in this state, so there is no damage.
    - The earliest re-hit is the (IFRAME_FRAMES+1)-th frame_tick after the hit tick.
  - DEAD: player_dead=1, invuln=0. HP holds 0 and no further hits occur.
- game_active=0 (synchronous, any state, highest priority after rst):
  - player_hp reloads to PLAYER_HP_MAX, state goes to ALIVE, counter=0, hit_pulse=0.
  - This restarts the player for the next game.
- No damage while boss_hp==0; a defeated boss is harmless.
- If frame_tick and a game_active fall coincide, the game_active reload wins.
- hit_pulse is never high for 2 consecutive cycles. player_hp never underflows and never exceeds PLAYER_HP_MAX.

Test Plan:
- Reset, then boxes apart (char_x=0, char_y=0; boss at 400,300 size 106x95), 10 frames → player_hp=6, hit_pulse never 1, invuln=0.
- Char at (380,290) overlapping the boss, game_active=1, frame_tick → one hit_pulse one cycle after the tick, player_hp=5, invuln=1.
- Keep overlapping for 60 frame_ticks → no further hit. On tick 61 → hit_pulse, player_hp=4.
- Edge touch: char_x=352 (352+48=400=boss_x) → no hit. char_x=353 → hit.
- Overlap with boss_hp=0 → no hit. Repeated hits with IFRAME_FRAMES=1 down to 0 → player_dead=1 and HP stays 0. Then drop game_active → player_hp=6, player_dead=0.
- Assert rst while in INVULN (counter=30) → all outputs return to reset values immediately, without waiting for a clk edge.
